// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, CSR ALU op encodings, mstatus bit positions
// and the redirect FSM state type. Used by the register file, CSR ALU and decoder.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic {
    CSR_IDLE     = 1'b0,
    CSR_REDIRECT = 1'b1
  } csr_state_e;

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with a software load port; load wins over increment and
// the count wraps naturally from all-ones to zero.
module csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_data;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational read with write bypass, WB commit, trap/mret
// updates and a fetch redirect pulse. Define CSR_COUNTERS_EN to add mcycle/minstret.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int               XLEN        = 64,
  parameter logic [XLEN-1:0]  RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_rillegal,
  input  logic            csr_we,
  input  logic [11:0]     csr_waddr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            instr_retire,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mstatus_mie,
  output csr_state_e      fsm_state
);

  logic            mie_bit_q;
  logic            mpie_bit_q;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] rdata_raw;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] target_pc;
  logic            commit_we;
  csr_state_e      state_q;
  csr_state_e      state_d;

  // A trap or mret in the same cycle flushes the instruction doing the write.
  assign commit_we = csr_we && !trap_valid && !mret_valid;

  // Value as it reads back after a write of d to addr.
  function automatic logic [XLEN-1:0] warl_mask(input logic [11:0] addr,
                                                input logic [XLEN-1:0] d);
    logic [XLEN-1:0] m;
    m = d;
    case (addr)
      CSR_MSTATUS: begin
        m = '0;
        m[MSTATUS_MIE]  = d[MSTATUS_MIE];
        m[MSTATUS_MPIE] = d[MSTATUS_MPIE];
        m[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MTVEC: m[1]   = 1'b0;
      CSR_MEPC:  m[1:0] = 2'b00;
      CSR_MIP:   m      = '0;
      default:   m      = d;
    endcase
    return m;
  endfunction

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE]  = mie_bit_q;
    mstatus_val[MSTATUS_MPIE] = mpie_bit_q;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle_val;
  logic [XLEN-1:0] minstret_val;

  csr_counter #(.W(XLEN)) u_mcycle (
    .clk       (clk),
    .rst       (rst),
    .load      (commit_we && csr_waddr == CSR_MCYCLE),
    .load_data (csr_wdata),
    .inc       (1'b1),
    .count     (mcycle_val)
  );

  csr_counter #(.W(XLEN)) u_minstret (
    .clk       (clk),
    .rst       (rst),
    .load      (commit_we && csr_waddr == CSR_MINSTRET),
    .load_data (csr_wdata),
    .inc       (instr_retire),
    .count     (minstret_val)
  );
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  always_comb begin
    rdata_raw    = '0;
    csr_rillegal = 1'b0;
    case (csr_raddr)
      CSR_MSTATUS:  rdata_raw = mstatus_val;
      CSR_MIE:      rdata_raw = mie_q;
      CSR_MTVEC:    rdata_raw = mtvec_q;
      CSR_MSCRATCH: rdata_raw = mscratch_q;
      CSR_MEPC:     rdata_raw = mepc_q;
      CSR_MCAUSE:   rdata_raw = mcause_q;
      CSR_MTVAL:    rdata_raw = mtval_q;
      CSR_MIP:      rdata_raw = '0;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   rdata_raw = mcycle_val;
      CSR_MINSTRET: rdata_raw = minstret_val;
`endif
      default:      csr_rillegal = 1'b1;
    endcase
    csr_rdata = rdata_raw;
    // Only the software write is forwarded; trap/mret effects appear after the edge.
    if (csr_we && csr_waddr == csr_raddr && !csr_rillegal) begin
      csr_rdata = warl_mask(csr_raddr, csr_wdata);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_bit_q  <= 1'b0;
      mpie_bit_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= warl_mask(CSR_MTVEC, RESET_MTVEC);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (trap_valid) begin
      mepc_q     <= warl_mask(CSR_MEPC, trap_pc);
      mcause_q   <= trap_cause;
      mtval_q    <= trap_tval;
      mpie_bit_q <= mie_bit_q;
      mie_bit_q  <= 1'b0;
    end else if (mret_valid) begin
      mie_bit_q  <= mpie_bit_q;
      mpie_bit_q <= 1'b1;
    end else if (csr_we) begin
      case (csr_waddr)
        CSR_MSTATUS: begin
          mie_bit_q  <= csr_wdata[MSTATUS_MIE];
          mpie_bit_q <= csr_wdata[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_q      <= csr_wdata;
        CSR_MTVEC:    mtvec_q    <= warl_mask(CSR_MTVEC, csr_wdata);
        CSR_MSCRATCH: mscratch_q <= csr_wdata;
        CSR_MEPC:     mepc_q     <= warl_mask(CSR_MEPC, csr_wdata);
        CSR_MCAUSE:   mcause_q   <= csr_wdata;
        CSR_MTVAL:    mtval_q    <= csr_wdata;
        default: ;
      endcase
    end
  end

  // Vectored mode only applies to interrupts; exceptions always go to the base.
  always_comb begin
    trap_base = {mtvec_q[XLEN-1:2], 2'b00};
    if (trap_valid) begin
      if (mtvec_q[0] && trap_cause[XLEN-1]) begin
        target_pc = trap_base + {trap_cause[XLEN-3:0], 2'b00};
      end else begin
        target_pc = trap_base;
      end
    end else begin
      target_pc = mepc_q;
    end
  end

  always_comb begin
    state_d = CSR_IDLE;
    if (trap_valid || mret_valid) begin
      state_d = CSR_REDIRECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CSR_IDLE;
      redirect_pc <= '0;
    end else begin
      state_q <= state_d;
      if (trap_valid || mret_valid) begin
        redirect_pc <= target_pc;
      end
    end
  end

  assign redirect_valid = (state_q == CSR_REDIRECT);
  assign mstatus_mie    = mie_bit_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: reset values, a table of write/read vectors,
// then hand-written trap, mret, redirect-extension and async-reset sequences.
module tb_csr_regfile;
  import csr_pkg::*;

  logic        clk;
  logic        rst;
  logic [11:0] csr_raddr;
  logic [63:0] csr_rdata;
  logic        csr_rillegal;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        trap_valid;
  logic [63:0] trap_pc;
  logic [63:0] trap_cause;
  logic [63:0] trap_tval;
  logic        mret_valid;
  logic        instr_retire;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mstatus_mie;
  csr_state_e  fsm_state;

  int passed = 0;
  int total  = 0;
  logic [63:0] exp_q[$];

  csr_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .csr_rillegal   (csr_rillegal),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .trap_tval      (trap_tval),
    .mret_valid     (mret_valid),
    .instr_retire   (instr_retire),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mstatus_mie    (mstatus_mie),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic [11:0] raddr;
    logic [63:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic read_check(input logic [11:0] addr, input logic [63:0] exp, input string name);
    csr_raddr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic idle_inputs();
    csr_raddr    = 12'h0;
    csr_we       = 1'b0;
    csr_waddr    = 12'h0;
    csr_wdata    = 64'h0;
    trap_valid   = 1'b0;
    trap_pc      = 64'h0;
    trap_cause   = 64'h0;
    trap_tval    = 64'h0;
    mret_valid   = 1'b0;
    instr_retire = 1'b0;
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_csr(input logic [11:0] addr, input logic [63:0] data);
    csr_we    = 1'b1;
    csr_waddr = addr;
    csr_wdata = data;
    tick();
    csr_we    = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 12'h341, 64'h8000_0007, 12'h341, 64'h8000_0004, 1'b0};
    vecs[1]  = '{1'b0, 12'h000, 64'h0, 12'h341, 64'h8000_0004, 1'b0};
    vecs[2]  = '{1'b1, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 12'h300, 64'h1888, 1'b0};
    vecs[3]  = '{1'b0, 12'h000, 64'h0, 12'h300, 64'h1888, 1'b0};
    vecs[4]  = '{1'b1, 12'h305, 64'h103, 12'h305, 64'h101, 1'b0};
    vecs[5]  = '{1'b1, 12'h340, 64'hDEAD_BEEF_CAFE_F00D, 12'h340, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[6]  = '{1'b1, 12'h344, 64'hFFFF, 12'h344, 64'h0, 1'b0};
    vecs[7]  = '{1'b1, 12'h304, 64'hAAAA, 12'h304, 64'hAAAA, 1'b0};
    vecs[8]  = '{1'b1, 12'h342, 64'h8000_0000_0000_0005, 12'h305, 64'h101, 1'b0};
    vecs[9]  = '{1'b0, 12'h000, 64'h0, 12'h342, 64'h8000_0000_0000_0005, 1'b0};
    vecs[10] = '{1'b1, 12'h343, 64'h1234, 12'h343, 64'h1234, 1'b0};
    vecs[11] = '{1'b1, 12'h7C0, 64'h55, 12'h7C0, 64'h0, 1'b1};
    vecs[12] = '{1'b1, 12'h300, 64'h0, 12'h300, 64'h1800, 1'b0};

    idle_inputs();
    rst = 1'b1;
    #2;
    // reset values (reads are combinational, so checked while rst is held)
    check("rst_redirect_valid", redirect_valid, 1'b0);
    check("rst_redirect_pc", redirect_pc, 64'h0);
    check("rst_mstatus_mie", mstatus_mie, 1'b0);
    check("rst_fsm_state", fsm_state, CSR_IDLE);
    read_check(12'h300, 64'h1800, "rst_mstatus");
    read_check(12'h304, 64'h0, "rst_mie");
    read_check(12'h305, 64'h0, "rst_mtvec");
    read_check(12'h340, 64'h0, "rst_mscratch");
    read_check(12'h341, 64'h0, "rst_mepc");
    read_check(12'h342, 64'h0, "rst_mcause");
    read_check(12'h343, 64'h0, "rst_mtval");
    read_check(12'h344, 64'h0, "rst_mip");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // table-driven write / bypass / readback
    for (int i = 0; i < 13; i++) begin
      csr_we    = vecs[i].we;
      csr_waddr = vecs[i].waddr;
      csr_wdata = vecs[i].wdata;
      csr_raddr = vecs[i].raddr;
      exp_q.push_back(vecs[i].exp_rdata);
      #1;
      check($sformatf("vec%0d_rdata", i), csr_rdata, exp_q.pop_front());
      check($sformatf("vec%0d_illegal", i), csr_rillegal, vecs[i].exp_ill);
      tick();
    end
    idle_inputs();

`ifdef CSR_COUNTERS_EN
    csr_we = 1'b1; csr_waddr = 12'hB00; csr_wdata = 64'hFFFF_FFFF_FFFF_FFFF; csr_raddr = 12'hB00;
    #1;
    check("mcycle_bypass", csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    csr_we = 1'b0;
    check("mcycle_loaded", csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("mcycle_wrap", csr_rdata, 64'h0);
    tick();
    check("mcycle_count", csr_rdata, 64'h1);
    csr_we = 1'b1; csr_waddr = 12'hB02; csr_wdata = 64'h5; instr_retire = 1'b1;
    csr_raddr = 12'hB02;
    tick();
    csr_we = 1'b0; instr_retire = 1'b0;
    check("minstret_write_wins", csr_rdata, 64'h5);
    tick();
    tick();
    check("minstret_idle", csr_rdata, 64'h5);
    instr_retire = 1'b1;
    tick();
    tick();
    instr_retire = 1'b0;
    check("minstret_retire", csr_rdata, 64'h7);
`else
    read_check(12'hB00, 64'h0, "mcycle_absent_rdata");
    check("mcycle_absent_illegal", csr_rillegal, 1'b1);
    read_check(12'hB02, 64'h0, "minstret_absent_rdata");
    check("minstret_absent_illegal", csr_rillegal, 1'b1);
`endif

    // trap entry; the concurrent mscratch write must be dropped
    write_csr(12'h300, 64'h8);
    write_csr(12'h305, 64'h100);
    check("setup_mie", mstatus_mie, 1'b1);
    trap_valid = 1'b1; trap_pc = 64'h2000; trap_cause = 64'h2; trap_tval = 64'h55;
    csr_we = 1'b1; csr_waddr = 12'h340; csr_wdata = 64'h77;
    tick();
    idle_inputs();
    check("trap_redirect_valid", redirect_valid, 1'b1);
    check("trap_redirect_pc", redirect_pc, 64'h100);
    check("trap_mstatus_mie", mstatus_mie, 1'b0);
    read_check(12'h341, 64'h2000, "trap_mepc");
    read_check(12'h342, 64'h2, "trap_mcause");
    read_check(12'h343, 64'h55, "trap_mtval");
    read_check(12'h300, 64'h1880, "trap_mstatus");
    read_check(12'h340, 64'hDEAD_BEEF_CAFE_F00D, "trap_mscratch_kept");
    tick();
    check("trap_pulse_end", redirect_valid, 1'b0);

    // vectored interrupt, then mret+write while still redirecting
    write_csr(12'h305, 64'h101);
    trap_valid = 1'b1; trap_pc = 64'h3000; trap_cause = 64'h8000_0000_0000_0007;
    tick();
    trap_valid = 1'b0;
    check("vec_redirect_valid", redirect_valid, 1'b1);
    check("vec_redirect_pc", redirect_pc, 64'h11C);
    mret_valid = 1'b1; csr_we = 1'b1; csr_waddr = 12'h340; csr_wdata = 64'h1111;
    tick();
    idle_inputs();
    check("mret_ext_valid", redirect_valid, 1'b1);
    check("mret_ext_pc", redirect_pc, 64'h3000);
    check("mret_mstatus_mie", mstatus_mie, 1'b0);
    read_check(12'h300, 64'h1880, "mret_mstatus");
    read_check(12'h340, 64'hDEAD_BEEF_CAFE_F00D, "mret_mscratch_kept");
    tick();
    check("mret_pulse_end", redirect_valid, 1'b0);

    // second mret: MPIE=1 now restores MIE=1
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    check("mret2_pc", redirect_pc, 64'h3000);
    check("mret2_mie", mstatus_mie, 1'b1);
    read_check(12'h300, 64'h1888, "mret2_mstatus");

    // exception with vectored mtvec goes to the base
    tick();
    trap_valid = 1'b1; trap_pc = 64'h4006; trap_cause = 64'h3;
    tick();
    trap_valid = 1'b0;
    check("exc_vec_base_pc", redirect_pc, 64'h100);
    read_check(12'h341, 64'h4004, "exc_mepc_masked");

    // async reset in the middle of a redirect pulse
    tick();
    trap_valid = 1'b1; trap_pc = 64'h5000; trap_cause = 64'h1;
    tick();
    trap_valid = 1'b0;
    check("pre_rst_valid", redirect_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", redirect_valid, 1'b0);
    check("async_rst_pc", redirect_pc, 64'h0);
    check("async_rst_state", fsm_state, CSR_IDLE);
    read_check(12'h300, 64'h1800, "async_rst_mstatus");
    read_check(12'h341, 64'h0, "async_rst_mepc");
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
